// File: rtl/ring_johnson_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ring_seq_pkg
// Shared types and constants for the ring/Johnson sequencer slice.
//   state_t       : sequencer FSM states (IDLE, RUN, DONE)
//   MODE_RING     : cmd_mode value selecting a plain left rotate
//   MODE_JOHNSON  : cmd_mode value selecting the twisted (Johnson) feedback
//   WIDTH_DEF     : default counter register width
//   CNT_W_DEF     : default width of the step count / steps_left
// ---------------------------------------------------------------------------
package ring_seq_pkg;

   localparam int   WIDTH_DEF    = 5;
   localparam int   CNT_W_DEF    = 8;

   localparam logic MODE_RING    = 1'b0;
   localparam logic MODE_JOHNSON = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/ring_johnson_sequencer_if.sv
// ---------------------------------------------------------------------------
// ring_johnson_sequencer_if
// Command and status bundle between a lab controller (master) and the
// sequencer (slave).
//   cmd_valid/cmd_ready : command handshake
//   cmd_mode            : 0 = ring, 1 = Johnson
//   cmd_seed            : initial counter value
//   cmd_steps           : number of shift steps
//   abort               : terminate a run early
//   q, busy, done       : counter value, run in progress, completion pulse
//   steps_left, err     : remaining steps, illegal-seed flag
// ---------------------------------------------------------------------------
interface ring_johnson_sequencer_if
   import ring_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
);

   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_mode;
   logic [WIDTH-1:0] cmd_seed;
   logic [CNT_W-1:0] cmd_steps;
   logic             abort;
   logic [WIDTH-1:0] q;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] steps_left;
   logic             err;

   modport master (
      output cmd_valid, cmd_mode, cmd_seed, cmd_steps, abort,
      input  cmd_ready, q, busy, done, steps_left, err
   );

   modport slave (
      input  cmd_valid, cmd_mode, cmd_seed, cmd_steps, abort,
      output cmd_ready, q, busy, done, steps_left, err
   );

endinterface

// File: rtl/ring_johnson_sequencer_next.sv
// ---------------------------------------------------------------------------
// ring_johnson_next
// Combinational next-value function of the ring/Johnson shift counter.
//   i_cur  : current counter value
//   i_mode : MODE_RING rotates left, MODE_JOHNSON inverts the bit fed
//            from position 0 into position 1
//   o_next : value after one shift
// ---------------------------------------------------------------------------
module ring_johnson_next
   import ring_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] i_cur,
   input  logic             i_mode,
   output logic [WIDTH-1:0] o_next
);

   always_comb begin
      o_next    = {i_cur[WIDTH-2:0], i_cur[WIDTH-1]};
      // The twist sits between bits 0 and 1, not at the wrap-around.
      o_next[1] = (i_mode == MODE_JOHNSON) ? ~i_cur[0] : i_cur[0];
   end

endmodule

// File: rtl/ring_johnson_sequencer.sv
// ---------------------------------------------------------------------------
// ring_johnson_sequencer
// Command-driven controller for the ring/Johnson shift counter. A command
// loads the seed, shifts for cmd_steps clocks, then pulses done for one
// cycle. abort during a run returns to IDLE with q/steps_left frozen.
//   clk  : rising-edge clock
//   clr  : asynchronous active-low reset
//   bus  : ring_johnson_sequencer_if.slave (command + status)
// Optional build macro SEQ_ONEHOT_CHECK_EN: when defined, err flags a
// ring-mode seed that is not one-hot (sticky until next accept); when
// undefined err is tied low.
// ---------------------------------------------------------------------------
module ring_johnson_sequencer
   import ring_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                      clk,
   input  logic                      clr,
   ring_johnson_sequencer_if.slave   bus
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_shift;
   logic [CNT_W-1:0] r_steps;
   logic             r_mode;
   logic             r_err;
   logic             w_err_nxt;
   logic             w_accept;
   logic             w_shift;

   assign w_accept = bus.cmd_valid && (r_state == IDLE);
   // abort wins over the shift on the same edge.
   assign w_shift  = (r_state == RUN) && !bus.abort;

`ifdef SEQ_ONEHOT_CHECK_EN
   assign w_err_nxt = (bus.cmd_mode == MODE_RING) && !$onehot(bus.cmd_seed);
`else
   assign w_err_nxt = 1'b0;
`endif

   ring_johnson_next #(.WIDTH(WIDTH)) u_next (
      .i_cur  (r_q),
      .i_mode (r_mode),
      .o_next (w_q_shift)
   );

   // State register
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (w_accept)
                  w_state_nxt = (bus.cmd_steps != '0) ? RUN : DONE;
         RUN:  if (bus.abort)
                  w_state_nxt = IDLE;
               else if (r_steps <= CNT_W'(1))
                  w_state_nxt = DONE;
         DONE: w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Datapath registers: counter, remaining steps, latched mode, err
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_q     <= '0;
         r_steps <= '0;
         r_mode  <= MODE_RING;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         r_q     <= bus.cmd_seed;
         r_steps <= bus.cmd_steps;
         r_mode  <= bus.cmd_mode;
         r_err   <= w_err_nxt;
      end else if (w_shift) begin
         r_q <= w_q_shift;
         if (r_steps != '0) r_steps <= r_steps - CNT_W'(1);
      end
   end

   // Outputs
   always_comb begin
      bus.cmd_ready  = (r_state == IDLE);
      bus.busy       = (r_state == RUN);
      bus.done       = (r_state == DONE);
      bus.q          = r_q;
      bus.steps_left = r_steps;
      bus.err        = r_err;
   end

endmodule

// File: tb/tb_ring_johnson_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ring_johnson_sequencer
// Drives directed and random commands into ring_johnson_sequencer and checks
// every cycle of each run against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_ring_johnson_sequencer;

   localparam int W = 5;
   localparam int C = 8;

   logic clk = 1'b0;
   logic clr = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   ring_johnson_sequencer_if #(.WIDTH(W), .CNT_W(C)) bus ();

   ring_johnson_sequencer #(.WIDTH(W), .CNT_W(C)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One shift: rotate left, then flip bit 1 in Johnson mode.
   function automatic logic [W-1:0] ref_next(input logic [W-1:0] cur, input logic mode);
      logic [W-1:0] rot;
      rot = (cur << 1) | (cur >> (W - 1));
      if (mode) rot = rot ^ W'(2);
      return rot;
   endfunction

   function automatic logic exp_err_f(input logic mode, input logic [W-1:0] seed);
`ifdef SEQ_ONEHOT_CHECK_EN
      return (mode == 1'b0) && ($countones(seed) != 1);
`else
      return 1'b0;
`endif
   endfunction

   task automatic wait_ready();
      int w;
      w = 0;
      while (bus.cmd_ready !== 1'b1 && w < 50) begin
         step();
         w++;
      end
      chk("ready_wait", 32'(bus.cmd_ready), 32'd1);
   endtask

   // Issue one command and check it cycle by cycle. abort_at = number of
   // completed shifts at which abort is raised (-1 = none). hold keeps
   // cmd_valid high with junk while not ready.
   task automatic run_cmd(input logic mode, input logic [W-1:0] seed, input int n,
                          input int abort_at, input bit hold);
      logic [W-1:0] cur;
      logic         e_err;
      wait_ready();
      bus.cmd_valid = 1'b1;
      bus.cmd_mode  = mode;
      bus.cmd_seed  = seed;
      bus.cmd_steps = C'(n);
      bus.abort     = ($urandom_range(0, 3) == 0);  // ignored in IDLE
      step();
      bus.abort = 1'b0;
      if (hold) begin
         bus.cmd_mode  = 1'($urandom);
         bus.cmd_seed  = W'($urandom);
         bus.cmd_steps = C'($urandom);
      end else begin
         bus.cmd_valid = 1'b0;
      end
      cur   = seed;
      e_err = exp_err_f(mode, seed);
      for (int k = 0; k < n; k++) begin
         chk("run_q",     32'(bus.q),          32'(cur));
         chk("run_left",  32'(bus.steps_left), 32'(n - k));
         chk("run_busy",  32'(bus.busy),       32'd1);
         chk("run_done",  32'(bus.done),       32'd0);
         chk("run_ready", 32'(bus.cmd_ready),  32'd0);
         chk("run_err",   32'(bus.err),        32'(e_err));
         if (k == abort_at) begin
            bus.abort = 1'b1;
            step();
            bus.abort     = 1'b0;
            bus.cmd_valid = 1'b0;
            chk("abort_q",     32'(bus.q),          32'(cur));
            chk("abort_left",  32'(bus.steps_left), 32'(n - k));
            chk("abort_done",  32'(bus.done),       32'd0);
            chk("abort_busy",  32'(bus.busy),       32'd0);
            chk("abort_ready", 32'(bus.cmd_ready),  32'd1);
            chk("abort_err",   32'(bus.err),        32'(e_err));
            return;
         end
         step();
         cur = ref_next(cur, mode);
      end
      chk("done_q",     32'(bus.q),          32'(cur));
      chk("done_pulse", 32'(bus.done),       32'd1);
      chk("done_busy",  32'(bus.busy),       32'd0);
      chk("done_ready", 32'(bus.cmd_ready),  32'd0);
      chk("done_left",  32'(bus.steps_left), 32'd0);
      chk("done_err",   32'(bus.err),        32'(e_err));
      if (hold) bus.abort = 1'b1;  // ignored in DONE
      step();
      bus.abort = 1'b0;
      chk("idle_q",     32'(bus.q),         32'(cur));
      chk("idle_done",  32'(bus.done),      32'd0);
      chk("idle_ready", 32'(bus.cmd_ready), 32'd1);
      chk("idle_err",   32'(bus.err),       32'(e_err));
      bus.cmd_valid = 1'b0;
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_mode  = 1'b0;
      bus.cmd_seed  = '0;
      bus.cmd_steps = '0;
      bus.abort     = 1'b0;

      // Reset
      #2 clr = 1'b0;
      #2;
      chk("rst_q",    32'(bus.q),          32'd0);
      chk("rst_left", 32'(bus.steps_left), 32'd0);
      chk("rst_busy", 32'(bus.busy),       32'd0);
      chk("rst_done", 32'(bus.done),       32'd0);
      chk("rst_err",  32'(bus.err),        32'd0);
      step();
      step();
      clr = 1'b1;
      step();
      chk("rst_ready", 32'(bus.cmd_ready), 32'd1);

      // Directed cases
      run_cmd(1'b0, 5'b00001, 3,  -1, 1'b0);
      chk("ring3_final", 32'(bus.q), 32'(5'b01000));
      run_cmd(1'b1, 5'b00000, 10, -1, 1'b0);
      chk("john10_final", 32'(bus.q), 32'(5'b00000));
      run_cmd(1'b0, 5'b10101, 0,  -1, 1'b1);
      chk("zero_final", 32'(bus.q), 32'(5'b10101));
      run_cmd(1'b0, 5'b00001, 8,  2,  1'b0);
      chk("abort_final", 32'(bus.q), 32'(5'b00100));
      run_cmd(1'b0, 5'b00011, 4,  -1, 1'b0);
      run_cmd(1'b1, 5'b00011, 2,  -1, 1'b0);
      run_cmd(1'b1, 5'b01010, 255, -1, 1'b1);

      // clr mid-run
      wait_ready();
      bus.cmd_valid = 1'b1;
      bus.cmd_mode  = 1'b0;
      bus.cmd_seed  = 5'b00001;
      bus.cmd_steps = 8'd5;
      step();
      bus.cmd_valid = 1'b0;
      step();
      step();
      chk("clr_pre_q", 32'(bus.q), 32'(5'b00100));
      clr = 1'b0;
      #1;
      chk("clr_q",    32'(bus.q),          32'd0);
      chk("clr_busy", 32'(bus.busy),       32'd0);
      chk("clr_left", 32'(bus.steps_left), 32'd0);
      chk("clr_done", 32'(bus.done),       32'd0);
      step();
      clr = 1'b1;
      run_cmd(1'b1, 5'b00100, 6, -1, 1'b0);

      // Random commands
      for (int i = 0; i < 40; i++) begin
         logic         m;
         logic [W-1:0] s;
         int           n;
         int           a;
         m = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 0) s = W'(1) << $urandom_range(0, W - 1);
         else                          s = W'($urandom);
         n = $urandom_range(0, 12);
         a = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
         run_cmd(m, s, n, a, 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
